// File: rtl/udp_req_range_splitter.sv
// ---------------------------------------------------------------------------
// udp_req_range_splitter
//
// Splits one sequence-range request {tag, start_seq, end_seq} into chunk
// requests of at most MAX_LEN consecutive sequence numbers each, so that a
// single DDR burst issued by the downstream pump never exceeds its buffer.
//
// Ports
//   clock          in   single clock domain
//   rst            in   asynchronous active-high reset
//   req_data       in   {tag, start_seq, end_seq}, MSB first
//   req_valid      in   request valid
//   req_ready      out  request accept (registered, high only while idle)
//   out_tag        out  chunk tag (copied from the request)
//   out_seq        out  first sequence number of the chunk
//   out_len        out  chunk item count, 1..MAX_LEN
//   out_last       out  final chunk of the request
//   out_valid      out  chunk valid
//   out_ready      in   chunk accept
//   err_range      out  one-cycle pulse when end_seq < start_seq (dropped)
//   stat_req_cnt   out  accepted-request counter
//   stat_chunk_cnt out  emitted-chunk counter
//
// Build option
//   UDP_REQ_SPLIT_STATS_EN  when defined, builds the two 32-bit wrapping
//                           statistics counters; otherwise both stat ports
//                           are tied to zero.
//
// FSM states
//   state   | meaning
//   S_IDLE  | waiting for a request, req_ready high
//   S_SPLIT | presenting chunks of the current request, req_ready low
// ---------------------------------------------------------------------------
module udp_req_range_splitter #(
    parameter int TAG_W   = 4,
    parameter int SEQ_W   = 64,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [TAG_W+2*SEQ_W-1:0] req_data,
    input  logic                     req_valid,
    output logic                     req_ready,
    output logic [TAG_W-1:0]         out_tag,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [LEN_W-1:0]         out_len,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_range,
    output logic [31:0]              stat_req_cnt,
    output logic [31:0]              stat_chunk_cnt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    // Remaining-count arithmetic is SEQ_W+1 bits wide so a request that spans
    // the whole sequence space (2^SEQ_W items) is still representable.
    localparam logic [SEQ_W:0]   C_MAX_W   = (SEQ_W + 1)'(MAX_LEN);
    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_req_ready;
    logic [TAG_W-1:0]   r_out_tag;
    logic [SEQ_W-1:0]   r_out_seq;
    logic [LEN_W-1:0]   r_out_len;
    logic               r_out_last;
    logic               r_out_valid;
    logic               r_err_range;
    logic [SEQ_W:0]     r_remain;

    logic               w_req_ready_nxt;
    logic [TAG_W-1:0]   w_tag_nxt;
    logic [SEQ_W-1:0]   w_seq_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic               w_last_nxt;
    logic               w_valid_nxt;
    logic               w_err_nxt;
    logic [SEQ_W:0]     w_remain_nxt;

    logic [TAG_W-1:0]   w_req_tag;
    logic [SEQ_W-1:0]   w_req_start;
    logic [SEQ_W-1:0]   w_req_end;
    logic               w_accept;
    logic               w_bad;
    logic               w_load;
    logic               w_hs;
    logic [SEQ_W:0]     w_req_span;
    logic [SEQ_W:0]     w_rem_after;
    logic [SEQ_W:0]     w_rem_src;
    logic [LEN_W-1:0]   w_len_of;
    logic               w_last_of;

    assign w_req_tag   = req_data[TAG_W+2*SEQ_W-1 -: TAG_W];
    assign w_req_start = req_data[2*SEQ_W-1 -: SEQ_W];
    assign w_req_end   = req_data[SEQ_W-1:0];

    // req_ready is registered and only high in S_IDLE, so there is no
    // combinational path from req_valid back to req_ready.
    assign w_accept = req_valid & r_req_ready;
    assign w_bad    = (w_req_end < w_req_start);
    assign w_load   = w_accept & ~w_bad;
    assign w_hs     = r_out_valid & out_ready;

    assign w_req_span  = {1'b0, w_req_end} - {1'b0, w_req_start} + (SEQ_W + 1)'(1);
    assign w_rem_after = r_remain - (SEQ_W + 1)'(r_out_len);

    // Length/last of the chunk that will be presented next, derived from
    // whichever remaining count is about to be loaded.
    assign w_rem_src = w_load ? w_req_span : w_rem_after;
    assign w_len_of  = (w_rem_src > C_MAX_W) ? C_MAX_LEN : w_rem_src[LEN_W-1:0];
    assign w_last_of = (w_rem_src <= C_MAX_W);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nxt = S_SPLIT;
                end
            end
            S_SPLIT: begin
                if (w_hs && r_out_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        w_valid_nxt     = (w_state_nxt == S_SPLIT);
        w_err_nxt       = w_accept & w_bad;
        w_tag_nxt       = r_out_tag;
        w_seq_nxt       = r_out_seq;
        w_len_nxt       = r_out_len;
        w_last_nxt      = r_out_last;
        w_remain_nxt    = r_remain;

        if (w_load) begin
            w_tag_nxt    = w_req_tag;
            w_seq_nxt    = w_req_start;
            w_remain_nxt = w_req_span;
            w_len_nxt    = w_len_of;
            w_last_nxt   = w_last_of;
        end else if (w_hs && !r_out_last) begin
            // No wrap is possible inside a request since end_seq >= start_seq.
            w_seq_nxt    = r_out_seq + SEQ_W'(r_out_len);
            w_remain_nxt = w_rem_after;
            w_len_nxt    = w_len_of;
            w_last_nxt   = w_last_of;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_req_ready <= 1'b0;
            r_out_tag   <= '0;
            r_out_seq   <= '0;
            r_out_len   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_range <= 1'b0;
            r_remain    <= '0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_out_tag   <= w_tag_nxt;
            r_out_seq   <= w_seq_nxt;
            r_out_len   <= w_len_nxt;
            r_out_last  <= w_last_nxt;
            r_out_valid <= w_valid_nxt;
            r_err_range <= w_err_nxt;
            r_remain    <= w_remain_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign out_tag   = r_out_tag;
    assign out_seq   = r_out_seq;
    assign out_len   = r_out_len;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign err_range = r_err_range;

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef UDP_REQ_SPLIT_STATS_EN
    logic [31:0] r_stat_req_cnt;
    logic [31:0] r_stat_chunk_cnt;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_stat_req_cnt   <= '0;
            r_stat_chunk_cnt <= '0;
        end else begin
            if (w_load) begin
                r_stat_req_cnt <= r_stat_req_cnt + 32'd1;
            end
            if (w_hs) begin
                r_stat_chunk_cnt <= r_stat_chunk_cnt + 32'd1;
            end
        end
    end

    assign stat_req_cnt   = r_stat_req_cnt;
    assign stat_chunk_cnt = r_stat_chunk_cnt;
`else
    assign stat_req_cnt   = 32'd0;
    assign stat_chunk_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_udp_req_range_splitter.sv
module tb_udp_req_range_splitter;

    localparam int TAG_W   = 4;
    localparam int SEQ_W   = 64;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    typedef logic [TAG_W+SEQ_W+LEN_W:0] chunk_t;

    logic                     clock;
    logic                     rst;
    logic [TAG_W+2*SEQ_W-1:0] req_data;
    logic                     req_valid;
    logic                     req_ready;
    logic [TAG_W-1:0]         out_tag;
    logic [SEQ_W-1:0]         out_seq;
    logic [LEN_W-1:0]         out_len;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;
    logic                     err_range;
    logic [31:0]              stat_req_cnt;
    logic [31:0]              stat_chunk_cnt;

    udp_req_range_splitter #(
        .TAG_W  (TAG_W),
        .SEQ_W  (SEQ_W),
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .out_tag       (out_tag),
        .out_seq       (out_seq),
        .out_len       (out_len),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .err_range     (err_range),
        .stat_req_cnt  (stat_req_cnt),
        .stat_chunk_cnt(stat_chunk_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    chunk_t exp_q[$];
    chunk_t obs_q[$];
    int     obs_cyc[$];
    int     exp_req   = 0;
    int     exp_chunk = 0;
    bit     err_seen  = 0;

    // Reference: walk the range in MAX_LEN steps with wide arithmetic; the
    // last chunk is the one whose final item equals end_seq.
    task automatic model_req(input logic [TAG_W-1:0] tag, input logic [SEQ_W-1:0] s,
                             input logic [SEQ_W-1:0] e);
        logic [SEQ_W:0] p;
        logic [SEQ_W:0] stop;
        logic [SEQ_W:0] n;
        logic [SEQ_W:0] len;
        p    = {1'b0, s};
        stop = {1'b0, e};
        while (p <= stop) begin
            n   = stop - p + 1;
            len = (n > MAX_LEN) ? (SEQ_W + 1)'(MAX_LEN) : n;
            exp_q.push_back({tag, p[SEQ_W-1:0], len[LEN_W-1:0], (p + len - 1) == stop});
            exp_chunk++;
            p = p + len;
        end
        exp_req++;
    endtask

    // Driver: called and returns at posedge+1.
    task automatic issue(input logic [TAG_W-1:0] tag, input logic [SEQ_W-1:0] s,
                         input logic [SEQ_W-1:0] e, output bit to);
        int n;
        n  = 0;
        to = 0;
        while (!req_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (!req_ready) to = 1;
        req_data  = {tag, s, e};
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    // Monitor: records handshaken chunks until the last one; counts any
    // change of outputs while stalled.
    task automatic collect(input int stall, input bit rnd, output int first_valid,
                           output bit to, output int unstable, output bit rdy_after);
        int     cyc;
        int     wcnt;
        bit     done;
        bit     prev_stall;
        chunk_t prev;
        chunk_t cur;
        cyc = 0; wcnt = 0; done = 0; prev_stall = 0; prev = '0;
        first_valid = -1; unstable = 0; rdy_after = 0; err_seen = 0;
        while (!done && cyc < 3000) begin
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
            end else if (out_valid) begin
                out_ready = (wcnt >= stall);
                wcnt++;
            end
            @(negedge clock);
            cur = {out_tag, out_seq, out_len, out_last};
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (!out_valid || cur !== prev)) unstable++;
            prev_stall = out_valid && !out_ready;
            prev       = cur;
            if (err_range) err_seen = 1;
            if (out_valid && out_ready) begin
                obs_q.push_back(cur);
                obs_cyc.push_back(cyc);
                wcnt = 0;
                if (out_last) done = 1;
            end
            @(posedge clock); #1;
            cyc++;
        end
        to = !done;
        if (done) rdy_after = req_ready;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clock); #1;
        rst = 1'b0;
        exp_req   = 0;
        exp_chunk = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        out_ready = 1'b0;
        @(posedge clock); #1;
        n_total++;
        if ({req_ready, out_valid, out_last, err_range} !== 4'b0000)
            $display("FAIL reset_ctrl got=%b exp=0000", {req_ready, out_valid, out_last, err_range});
        else n_pass++;
        n_total++;
        if ({out_tag, out_seq, out_len} !== '0)
            $display("FAIL reset_data got=%h exp=0", {out_tag, out_seq, out_len});
        else n_pass++;
        n_total++;
        if ({stat_req_cnt, stat_chunk_cnt} !== 64'd0)
            $display("FAIL reset_stats got=%h exp=0", {stat_req_cnt, stat_chunk_cnt});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_early got=%b exp=0", req_ready);
        else n_pass++;
        @(posedge clock); #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready_rise got=%b exp=1", req_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit to; int fv; int uns; bit ra;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        model_req(4'h3, 64'd100, 64'd140);
        issue(4'h3, 64'd100, 64'd140, to);
        collect(0, 0, fv, to, uns, ra);
        n_total++;
        if (to) $display("FAIL basic_timeout got=1 exp=0"); else n_pass++;
        n_total++;
        if (fv !== 0) $display("FAIL basic_latency got=%0d exp=0", fv); else n_pass++;
        n_total++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL basic_chunk%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            else n_pass++;
            n_total++;
            if (obs_cyc[i] !== i) $display("FAIL basic_cycle%0d got=%0d exp=%0d", i, obs_cyc[i], i);
            else n_pass++;
        end
        n_total++;
        if (ra !== 1'b1) $display("FAIL basic_ready_after got=%b exp=1", ra); else n_pass++;
    endtask

    task automatic test_single();
        bit to; int fv; int uns; bit ra;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        model_req(4'hA, 64'd5, 64'd5);
        issue(4'hA, 64'd5, 64'd5, to);
        collect(0, 0, fv, to, uns, ra);
        n_total++;
        if (to || obs_q.size() != 1) $display("FAIL single_count got=%0d exp=1", obs_q.size());
        else n_pass++;
        n_total++;
        if (obs_q.size() > 0 && obs_q[0] !== exp_q[0])
            $display("FAIL single_chunk got=%h exp=%h", obs_q[0], exp_q[0]);
        else n_pass++;
        n_total++;
        if (err_seen) $display("FAIL single_err got=1 exp=0"); else n_pass++;
    endtask

    task automatic test_bad_range();
        req_data  = {4'h1, 64'd200, 64'd199};
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_data  = {4'h2, 64'd7, 64'd0};
        @(negedge clock);
        n_total++;
        if ({err_range, out_valid, req_ready} !== 3'b101)
            $display("FAIL bad_first got=%b exp=101", {err_range, out_valid, req_ready});
        else n_pass++;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if ({err_range, out_valid, req_ready} !== 3'b101)
            $display("FAIL bad_second got=%b exp=101", {err_range, out_valid, req_ready});
        else n_pass++;
        @(posedge clock); #1;
        @(negedge clock);
        n_total++;
        if ({err_range, out_valid, req_ready} !== 3'b001)
            $display("FAIL bad_after got=%b exp=001", {err_range, out_valid, req_ready});
        else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic test_top_of_range();
        bit to; int fv; int uns; bit ra;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        model_req(4'h5, 64'hFFFF_FFFF_FFFF_FFE0, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(4'h5, 64'hFFFF_FFFF_FFFF_FFE0, 64'hFFFF_FFFF_FFFF_FFFF, to);
        collect(0, 0, fv, to, uns, ra);
        n_total++;
        if (to || obs_q.size() != 2) $display("FAIL top_count got=%0d exp=2", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL top_chunk%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit to; int fv; int uns; bit ra;
        logic [31:0] er; logic [31:0] ec;
        do_reset();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        model_req(4'h7, 64'd0, 64'd47);
        issue(4'h7, 64'd0, 64'd47, to);
        collect(10, 0, fv, to, uns, ra);
        n_total++;
        if (to || obs_q.size() != 3) $display("FAIL stall_count got=%0d exp=3", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL stall_chunk%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            else n_pass++;
            n_total++;
            if (obs_cyc[i] !== 10 + 11 * i)
                $display("FAIL stall_cycle%0d got=%0d exp=%0d", i, obs_cyc[i], 10 + 11 * i);
            else n_pass++;
        end
        n_total++;
        if (uns !== 0) $display("FAIL stall_hold got=%0d exp=0", uns); else n_pass++;
`ifdef UDP_REQ_SPLIT_STATS_EN
        er = 32'(exp_req); ec = 32'(exp_chunk);
`else
        er = 32'd0; ec = 32'd0;
`endif
        n_total++;
        if ({stat_req_cnt, stat_chunk_cnt} !== {er, ec})
            $display("FAIL stall_stats got=%0d,%0d exp=%0d,%0d", stat_req_cnt, stat_chunk_cnt, er, ec);
        else n_pass++;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_split();
        bit to; int fv; int uns; bit ra;
        issue(4'h9, 64'd0, 64'd63, to);
        out_ready = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        n_total++;
        if ({out_valid, out_seq} !== {1'b1, 64'd16})
            $display("FAIL rstmid_second got=%b,%0d exp=1,16", out_valid, out_seq);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({req_ready, out_valid, out_last, err_range, out_tag, out_seq, out_len} !== '0)
            $display("FAIL rstmid_clear got=%h exp=0",
                     {req_ready, out_valid, out_last, err_range, out_tag, out_seq, out_len});
        else n_pass++;
        n_total++;
        if ({stat_req_cnt, stat_chunk_cnt} !== 64'd0)
            $display("FAIL rstmid_stats got=%h exp=0", {stat_req_cnt, stat_chunk_cnt});
        else n_pass++;
        exp_req = 0; exp_chunk = 0;
        @(posedge clock); #1;
        rst = 1'b0;
        @(posedge clock); #1;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        model_req(4'h9, 64'd10, 64'd12);
        issue(4'h9, 64'd10, 64'd12, to);
        collect(0, 0, fv, to, uns, ra);
        n_total++;
        if (to || obs_q.size() != 1) $display("FAIL rstmid_count got=%0d exp=1", obs_q.size());
        else n_pass++;
        n_total++;
        if (obs_q.size() > 0 && obs_q[0] !== exp_q[0])
            $display("FAIL rstmid_chunk got=%h exp=%h", obs_q[0], exp_q[0]);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rstmid_stale got=%b exp=0", out_valid); else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic test_random();
        bit to; int fv; int uns; bit ra;
        logic [SEQ_W-1:0] s; logic [SEQ_W-1:0] e; logic [SEQ_W:0] ew;
        logic [TAG_W-1:0] tag;
        logic [31:0] er; logic [31:0] ec;
        int bad_fail; int chunk_fail; int hold_fail;
        bad_fail = 0; chunk_fail = 0; hold_fail = 0;
        for (int it = 0; it < 40; it++) begin
            tag = 4'($urandom);
            s   = {$urandom, $urandom};
            if (it % 7 == 0) s = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 60));
            if ($urandom_range(0, 5) == 0) begin
                s = s | 64'h100;
                e = s - 64'($urandom_range(1, 200));
                issue(tag, s, e, to);
                @(negedge clock);
                if (to || err_range !== 1'b1 || out_valid !== 1'b0) bad_fail++;
                @(posedge clock); #1;
            end else begin
                ew = {1'b0, s} + (SEQ_W + 1)'($urandom_range(0, 70));
                e  = ew[SEQ_W] ? 64'hFFFF_FFFF_FFFF_FFFF : ew[SEQ_W-1:0];
                exp_q.delete(); obs_q.delete(); obs_cyc.delete();
                model_req(tag, s, e);
                issue(tag, s, e, to);
                collect(0, 1, fv, to, uns, ra);
                if (to || obs_q.size() != exp_q.size()) chunk_fail++;
                for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
                    if (obs_q[i] !== exp_q[i]) chunk_fail++;
                if (uns != 0 || fv != 0 || err_seen) hold_fail++;
            end
        end
        n_total++;
        if (bad_fail !== 0) $display("FAIL rand_err got=%0d exp=0", bad_fail); else n_pass++;
        n_total++;
        if (chunk_fail !== 0) $display("FAIL rand_chunks got=%0d exp=0", chunk_fail); else n_pass++;
        n_total++;
        if (hold_fail !== 0) $display("FAIL rand_hold got=%0d exp=0", hold_fail); else n_pass++;
`ifdef UDP_REQ_SPLIT_STATS_EN
        er = 32'(exp_req); ec = 32'(exp_chunk);
`else
        er = 32'd0; ec = 32'd0;
`endif
        n_total++;
        if ({stat_req_cnt, stat_chunk_cnt} !== {er, ec})
            $display("FAIL rand_stats got=%0d,%0d exp=%0d,%0d", stat_req_cnt, stat_chunk_cnt, er, ec);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_bad_range();
        test_top_of_range();
        test_stall();
        test_reset_mid_split();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
